// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the memory array.
// slave: arbiter view; master: requester/memory-side view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;
  // memory array
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_valid, d_err, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_valid, d_err, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter sharing one word memory between fetch and load/store.
// Ports: clk, rst (async, active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    RET_NONE,
    RET_IF,
    RET_D_OK,
    RET_D_ERR
  } ret_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  ret_e       ret_q, ret_d;
  logic       st_q, st_d;
  logic [3:0] starve_q, starve_d;

  logic starved;
  logic aligned;
  logic if_win;
  logic d_win;
  logic unused_addr_bits;

  assign starved = (starve_q == SMAX);
  assign aligned = (bus.d_addr[1:0] == 2'b00);

  // fetch low bits never reach the memory
  assign unused_addr_bits = ^bus.if_addr[1:0];

  // data wins ties unless fetch has been starved out
  always_comb begin
    if_win = rst & bus.if_req
           & (~bus.d_req | starved);
    d_win  = rst & bus.d_req & ~if_win;
  end

  assign bus.if_gnt = if_win;
  assign bus.d_gnt  = d_win;

  always_comb begin
    bus.mem_en    = if_win | d_win;
    bus.mem_we    = d_win & bus.d_we & aligned;
    bus.mem_wdata = bus.d_wdata;
    if (if_win)
      bus.mem_addr = bus.if_addr[ADDR_W-1:2];
    else
      bus.mem_addr = bus.d_addr[ADDR_W-1:2];
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_win)
      starve_d = 4'd0;
    else if (!starved)
      starve_d = starve_q + 4'd1;
  end

  always_comb begin
    ret_d = RET_NONE;
    st_d  = 1'b0;
    unique case (1'b1)
      if_win: ret_d = RET_IF;
      d_win: begin
        ret_d = aligned ? RET_D_OK : RET_D_ERR;
        st_d  = bus.d_we;
      end
      default: ret_d = RET_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q    <= RET_NONE;
      st_q     <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      ret_q    <= ret_d;
      st_q     <= st_d;
      starve_q <= starve_d;
    end
  end

  // return side: memory data is only valid in the cycle after the grant
  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_rdata = '0;
    bus.d_valid  = 1'b0;
    bus.d_err    = 1'b0;
    bus.d_rdata  = '0;
    unique case (ret_q)
      RET_IF: begin
        bus.if_valid = 1'b1;
        bus.if_rdata = bus.mem_rdata;
      end
      RET_D_OK: begin
        bus.d_valid = 1'b1;
        if (!st_q)
          bus.d_rdata = bus.mem_rdata;
      end
      RET_D_ERR: begin
        bus.d_valid = 1'b1;
        bus.d_err   = 1'b1;
      end
      default: bus.d_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter.
// Holds a memory array and a priority/starvation reference model.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic clk;
  logic rst;
  logic preload;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'h8C010004;
    return 32'hC0DE0000 | 32'(i * 3);
  endfunction

  // memory array seen by the DUT
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      else
        bus.mem_rdata <= mem[bus.mem_addr[5:0]];
    end
  end

  // reference model state
  logic [31:0] ref_mem [64];
  int          streak;     // consecutive cycles fetch asked and lost
  int          pend_kind;  // 0 none, 1 fetch, 2 data ok, 3 data err
  logic [31:0] pend_data;
  logic        last_ig, last_dg;

  int checks;
  int failures;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, check at negedge, advance model
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd);
    logic eig, edg, mis, ewe;
    logic [31:0] ea;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    @(negedge clk);
    mis = (da[1:0] != 2'b00);
    eig = rst && ir && (!dr || streak == SMAX);
    edg = rst && dr && !eig;
    ewe = edg && dw && !mis;
    ea  = eig ? ia : da;
    chk("if_gnt", 32'(bus.if_gnt), 32'(eig));
    chk("d_gnt", 32'(bus.d_gnt), 32'(edg));
    chk("mem_en", 32'(bus.mem_en), 32'(eig | edg));
    chk("mem_we", 32'(bus.mem_we), 32'(ewe));
    if (eig || edg)
      chk("mem_addr", 32'(bus.mem_addr), {2'b00, ea[31:2]});
    if (ewe)
      chk("mem_wdata", bus.mem_wdata, dwd);
    chk("if_valid", 32'(bus.if_valid), 32'(pend_kind == 1));
    chk("if_rdata", bus.if_rdata,
        (pend_kind == 1) ? pend_data : 32'h0);
    chk("d_valid", 32'(bus.d_valid), 32'(pend_kind >= 2));
    chk("d_err", 32'(bus.d_err), 32'(pend_kind == 3));
    chk("d_rdata", bus.d_rdata,
        (pend_kind == 2) ? pend_data : 32'h0);
    last_ig = eig;
    last_dg = edg;
    if (!rst) begin
      pend_kind = 0;
      streak    = 0;
    end else begin
      if (eig) begin
        pend_kind = 1;
        pend_data = ref_mem[ia[7:2]];
      end else if (edg && mis) begin
        pend_kind = 3;
        pend_data = 32'h0;
      end else if (edg) begin
        pend_kind = 2;
        pend_data = dw ? 32'h0 : ref_mem[da[7:2]];
        if (dw) ref_mem[da[7:2]] = dwd;
      end else begin
        pend_kind = 0;
      end
      if (ir && !eig)
        streak = (streak < SMAX) ? streak + 1 : SMAX;
      else
        streak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        pir, pdr, pdw;
    logic [31:0] pia, pda, pdwd;
    checks    = 0;
    failures  = 0;
    streak    = 0;
    pend_kind = 0;
    pend_data = 32'h0;
    last_ig   = 1'b0;
    last_dg   = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    rst     = 1'b0;
    preload = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req  = 1'b0; bus.d_we    = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0;
    @(posedge clk); #1;
    preload = 1'b0;

    // reset held with both requesting: nothing granted, nothing valid
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    rst = 1'b1;

    // first cycle after release: data wins
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("first_d", 32'(last_dg), 32'h1);
    idle();

    // plain fetch of word 2
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fetch_data", bus.if_rdata, 32'h8C010004);
    idle();

    // store then load back-to-back
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    chk("st_ack", 32'(bus.d_valid), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("ld_data", bus.d_rdata, 32'hDEADBEEF);
    idle();

    // both held high: d,d,d,d,if repeating
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h4, 1'b1, 1'b0, 32'h80, 32'h0);
      chk("starve_pat", 32'(last_ig), 32'((i % 5) == 4));
    end
    idle();

    // misaligned store: error return, word 16 untouched
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h42, 32'h12345678);
    chk("mis_err", 32'(bus.d_err), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("mis_keep", bus.d_rdata, 32'hDEADBEEF);
    idle();

    // reset in the middle of the return cycle
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_rst_v", 32'(bus.if_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_if_v", 32'(bus.if_valid), 32'h0);
    chk("rst_d_v", 32'(bus.d_valid), 32'h0);
    pend_kind = 0;
    streak    = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    idle();

    // randomized traffic; requesters hold until granted
    pir = 1'b0; pdr = 1'b0; pdw = 1'b0;
    pia = '0; pda = '0; pdwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pir && ($urandom_range(0, 1) == 1)) begin
        pir = 1'b1;
        pia = $urandom;
      end
      if (!pdr && ($urandom_range(0, 2) != 0)) begin
        pdr  = 1'b1;
        pdw  = 1'($urandom_range(0, 1));
        pda  = $urandom;
        if ($urandom_range(0, 7) != 0) pda[1:0] = 2'b00;
        pdwd = $urandom;
      end
      step(pir, pia, pdr, pdw, pda, pdwd);
      if (last_ig) pir = 1'b0;
      if (last_dg) pdr = 1'b0;
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 32-bit word memory between the instruction-fetch requester and the load/store requester.
- Replaces fixed fetch/execute phase alternation with per-cycle arbitration. Throughput is one access per cycle; latency is fixed at one cycle.
- Data port has priority. A starvation counter guarantees fetch forward progress.
- Sits between the control/PC logic and the memory array.

Parameters:
- ADDR_W, 32, byte-address width of both requesters.
- DATA_W, 32, word width.
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch gets priority (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_valid  out  1  fetch data returned this cycle.
- if_rdata  out  DATA_W  fetch word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_valid  out  1  load data / store acknowledge this cycle.
- d_err  out  1  misaligned data access, qualified by d_valid.
- d_rdata  out  DATA_W  load word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W-2  word address (byte address [ADDR_W-1:2]).
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- Clock is clk only. Reset is asynchronous and active-low: rst is the reset port, asserted at 0.
- Reset values: starve_cnt = 0, ret_sel = NONE, if_valid = d_valid = d_err = 0, rdata outputs = 0.
  - While rst = 0, if_gnt, d_gnt, mem_en and mem_we are forced to 0.

Arbitration (combinational, every cycle):
- If only one requester asserts req, it is granted.
- If both request:
  - d wins, unless starve_cnt == STARVE_MAX, in which case if wins.
- At most one gnt is high per cycle. A granted request is consumed that cycle; the requester holds req/addr until it sees gnt.

Memory drive (in the grant cycle):
- mem_en = 1.
- mem_addr = granted addr [ADDR_W-1:2].
- mem_we = d_we & d_gnt & aligned.
- mem_wdata = d_wdata.
- No grant: mem_en = 0, mem_we = 0; other memory outputs are don't-care.

Return tracking (registered ret_sel in {NONE, IF, D_OK, D_ERR}):
- Grant in cycle N sets ret_sel for cycle N+1. No grant sets NONE.

Cycle N+1 outputs:
- IF: if_valid = 1, if_rdata = mem_rdata.
- D_OK, load: d_valid = 1, d_rdata = mem_rdata.
- D_OK, store: d_valid = 1, d_rdata = 0.
- D_ERR: d_valid = 1, d_err = 1, d_rdata = 0.
- All other cases: valid/err = 0, rdata = 0.

Alignment:
- d_addr[1:0] != 0 is granted but suppresses mem_we. The read is harmless and its data is discarded.
- if_addr low bits are ignored.

Starvation counter (4-bit):
- Increments when if_req = 1 and if_gnt = 0.
- Saturates at STARVE_MAX.
- Clears to 0 on if_gnt or when if_req = 0.

Back-to-back: a new grant in the same cycle as a return is legal and required (full pipelining).

Reset mid-operation: an outstanding return is dropped, and no valid is asserted after reset release.

Test Plan:
- Reset with rst = 0 while if_req = 1, d_req = 1 -> all gnt/valid/mem_en = 0. After release, the first cycle grants d (starve_cnt = 0).
- if_req only, if_addr = 0x00000008, memory word 2 = 0x8C010004 -> if_gnt in cycle N, mem_addr = 2, mem_en = 1; if_valid = 1 with if_rdata = 0x8C010004 in N+1.
- Store then load: d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF, then d_we = 0, d_addr = 0x40 on consecutive cycles -> mem_we = 1 with mem_addr = 16; store ack d_valid = 1, d_rdata = 0 in the next cycle (concurrent with the load grant); d_valid = 1 with d_rdata = 0xDEADBEEF one cycle later.
- Both requesters held high continuously, STARVE_MAX = 4 -> grant pattern d,d,d,d,if repeating; if_gnt on every 5th cycle; starve_cnt returns to 0 after each if_gnt.
- Misaligned store d_addr = 0x42 -> d_gnt = 1, mem_we = 0; next cycle d_valid = 1, d_err = 1, and memory word 16 is unchanged.
- Grant at cycle N, rst = 0 asserted mid cycle N+1 -> if_valid/d_valid drop to 0 immediately; no stale valid after release.
